vend_input_conditioner: RTL and testbench

- Sits directly upstream of the vending FSM: converts five raw, asynchronous, bouncy board inputs (nickel, dime, quarter, soda, diet) into clean one-cycle event pulses, at most one per clock.
- Synchronises, debounces and rising-edge detects each input, then queues the edge as a pending request.
- Arbitrates pending requests by fixed priority.
- Reports merged (lost) events and keeps a running count of accepted coins.

---
 rtl/vend_pkg.sv | 37 +++
 rtl/vend_input_conditioner_debounce.sv | 57 +++++
 rtl/vend_input_conditioner.sv | 89 ++++++++
 tb/tb_vend_input_conditioner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine front end: channel indices,
// arbitration order and coin values used by the conditioner and the FSM.
package vend_pkg;

    localparam int NUM_CH  = 5;

    localparam int CH_QU   = 0;
    localparam int CH_DI   = 1;
    localparam int CH_NI   = 2;
    localparam int CH_SODA = 3;
    localparam int CH_DIET = 4;

    // Arbitration order, highest priority first.
    localparam int PRIO_ORDER [NUM_CH] = '{CH_QU, CH_DI, CH_NI, CH_SODA, CH_DIET};

    // Coin values in cents, shared with the vending FSM.
    localparam int COIN_VAL_NI = 5;
    localparam int COIN_VAL_DI = 10;
    localparam int COIN_VAL_QU = 25;

    typedef logic [NUM_CH-1:0] ch_vec_t;

    // One-hot grant of the highest-priority requesting channel (zero if none).
    // Walks from lowest to highest priority so the last hit wins.
    function automatic ch_vec_t pick_highest(input ch_vec_t req);
        ch_vec_t g;
        g = '0;
        for (int p = NUM_CH - 1; p >= 0; p--) begin
            if (req[PRIO_ORDER[p]]) begin
                g = '0;
                g[PRIO_ORDER[p]] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/vend_input_conditioner_debounce.sv
// One input channel: two-flop synchroniser, counter debouncer and
// rising-edge detect. edge_pulse is high for one cycle after stable rises.
module debounce_channel
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic rst,
    input  logic raw,
    output logic edge_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg, stable_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          edge_reg, edge_next;

    // Count consecutive disagreeing cycles; flip stable on the last one.
    always_comb begin
        stable_next = stable_reg;
        cnt_next    = '0;
        edge_next   = 1'b0;
        if (sync2_reg != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
                stable_next = ~stable_reg;
                edge_next   = ~stable_reg;   // only 0->1 flips are reported
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // Synchroniser and debouncer state, cleared by the active-low reset.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
            edge_reg   <= 1'b0;
        end else begin
            sync1_reg  <= raw;
            sync2_reg  <= sync1_reg;
            stable_reg <= stable_next;
            cnt_reg    <= cnt_next;
            edge_reg   <= edge_next;
        end
    end

    assign edge_pulse = edge_reg;

endmodule

// File: rtl/vend_input_conditioner.sv
// Conditions five raw board inputs into single-cycle, mutually exclusive
// event pulses for the vending FSM, with merge reporting and a coin count.
module vend_input_conditioner
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             raw_ni,
    input  logic             raw_di,
    input  logic             raw_qu,
    input  logic             raw_soda,
    input  logic             raw_diet,
    output logic             ni,
    output logic             di,
    output logic             qu,
    output logic             soda,
    output logic             diet,
    output logic             overrun,
    output logic [CNT_W-1:0] coin_count
);

    ch_vec_t          raw_vec;
    ch_vec_t          edge_vec;
    ch_vec_t          pending_reg, pending_next;
    ch_vec_t          grant;
    ch_vec_t          out_reg;
    logic             overrun_reg, overrun_next;
    logic [CNT_W-1:0] coin_count_reg, coin_count_next;
    logic             coin_grant;

    assign raw_vec[CH_QU]   = raw_qu;
    assign raw_vec[CH_DI]   = raw_di;
    assign raw_vec[CH_NI]   = raw_ni;
    assign raw_vec[CH_SODA] = raw_soda;
    assign raw_vec[CH_DIET] = raw_diet;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .CLK        (CLK),
                .rst        (rst),
                .raw        (raw_vec[gi]),
                .edge_pulse (edge_vec[gi])
            );
        end
    endgenerate

    // Serve one pending channel per cycle; a new edge re-arms its bit, and
    // an edge on a bit that stays pending is a merge.
    always_comb begin
        grant           = pick_highest(pending_reg);
        pending_next    = (pending_reg & ~grant) | edge_vec;
        overrun_next    = |(edge_vec & pending_reg & ~grant);
        coin_grant      = grant[CH_QU] | grant[CH_DI] | grant[CH_NI];
        coin_count_next = coin_count_reg;
        if (coin_grant) begin
            coin_count_next = coin_count_reg + 1'b1;
        end
    end

    // Pending requests, registered pulses and coin counter.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            pending_reg    <= '0;
            out_reg        <= '0;
            overrun_reg    <= 1'b0;
            coin_count_reg <= '0;
        end else begin
            pending_reg    <= pending_next;
            out_reg        <= grant;
            overrun_reg    <= overrun_next;
            coin_count_reg <= coin_count_next;
        end
    end

    assign qu         = out_reg[CH_QU];
    assign di         = out_reg[CH_DI];
    assign ni         = out_reg[CH_NI];
    assign soda       = out_reg[CH_SODA];
    assign diet       = out_reg[CH_DIET];
    assign overrun    = overrun_reg;
    assign coin_count = coin_count_reg;

endmodule

// File: tb/tb_vend_input_conditioner.sv
// Directed bench for vend_input_conditioner. Three instances share stimulus:
// dut_a (debounce 4, 8-bit count), dut_b (debounce 4, 2-bit count, wrap) and
// dut_c (debounce 1, used where merge / re-arm timing needs short debounce).
module tb_vend_input_conditioner;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst;
    logic raw_ni, raw_di, raw_qu, raw_soda, raw_diet;

    logic ni_a, di_a, qu_a, soda_a, diet_a, ov_a;
    logic ni_b, di_b, qu_b, soda_b, diet_b, ov_b;
    logic ni_c, di_c, qu_c, soda_c, diet_c, ov_c;
    logic [7:0] cc_a;
    logic [1:0] cc_b;
    logic [7:0] cc_c;

    // bit order: 0 qu, 1 di, 2 ni, 3 soda, 4 diet, 5 overrun
    wire [5:0] out_a = {ov_a, diet_a, soda_a, ni_a, di_a, qu_a};
    wire [5:0] out_b = {ov_b, diet_b, soda_b, ni_b, di_b, qu_b};
    wire [5:0] out_c = {ov_c, diet_c, soda_c, ni_c, di_c, qu_c};

    vend_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut_a (
        .CLK(CLK), .rst(rst), .raw_ni(raw_ni), .raw_di(raw_di), .raw_qu(raw_qu),
        .raw_soda(raw_soda), .raw_diet(raw_diet), .ni(ni_a), .di(di_a), .qu(qu_a),
        .soda(soda_a), .diet(diet_a), .overrun(ov_a), .coin_count(cc_a));

    vend_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut_b (
        .CLK(CLK), .rst(rst), .raw_ni(raw_ni), .raw_di(raw_di), .raw_qu(raw_qu),
        .raw_soda(raw_soda), .raw_diet(raw_diet), .ni(ni_b), .di(di_b), .qu(qu_b),
        .soda(soda_b), .diet(diet_b), .overrun(ov_b), .coin_count(cc_b));

    vend_input_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut_c (
        .CLK(CLK), .rst(rst), .raw_ni(raw_ni), .raw_di(raw_di), .raw_qu(raw_qu),
        .raw_soda(raw_soda), .raw_diet(raw_diet), .ni(ni_c), .di(di_c), .qu(qu_c),
        .soda(soda_c), .diet(diet_c), .overrun(ov_c), .coin_count(cc_c));

    int n_cmp = 0;
    int n_err = 0;

    // per-window accumulators for the monitored instance
    int mon_sel;
    int cyc_no;
    int multi;
    int pcnt [6];
    int first_at [6];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_acc();
        for (int i = 0; i < 6; i++) begin
            pcnt[i]     = 0;
            first_at[i] = -1;
        end
        multi  = 0;
        cyc_no = 0;
    endtask

    // Advance to the next falling edge and record which outputs are high.
    task automatic cyc();
        logic [5:0] v;
        @(negedge CLK);
        case (mon_sel)
            0:       v = out_a;
            1:       v = out_b;
            default: v = out_c;
        endcase
        for (int i = 0; i < 6; i++) begin
            if (v[i]) begin
                if (pcnt[i] == 0) first_at[i] = cyc_no;
                pcnt[i]++;
            end
        end
        if ($countones(v[4:0]) > 1) multi++;
        cyc_no++;
    endtask

    task automatic apply_reset();
        raw_ni = 0; raw_di = 0; raw_qu = 0; raw_soda = 0; raw_diet = 0;
        rst = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_out_a", int'(out_a), 0);
        chk("reset_cc_a", int'(cc_a), 0);
        chk("reset_cc_b", int'(cc_b), 0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        raw_ni = 0; raw_di = 0; raw_qu = 0; raw_soda = 0; raw_diet = 0;
        mon_sel = 0;
        clear_acc();

        // 1. Clean quarter: pulse at index 7 (DEBOUNCE_CYCLES+3)
        apply_reset();
        mon_sel = 0;
        clear_acc();
        raw_qu = 1;
        repeat (15) cyc();
        chk("clean_qu_at", first_at[0], 7);
        chk("clean_qu_cnt", pcnt[0], 1);
        chk("clean_others", pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4] + pcnt[5], 0);
        chk("clean_cc", int'(cc_a), 1);
        $display("clean quarter: qu at %0d, coin_count %0d", first_at[0], cc_a);

        // 2. Bounce rejection: 2-cycle toggles never settle
        apply_reset();
        clear_acc();
        for (int c = 0; c < 20; c++) begin
            raw_di = ((c / 2) % 2 == 0);
            cyc();
        end
        chk("bounce_no_pulse", pcnt[1], 0);
        clear_acc();
        raw_di = 1;
        repeat (15) cyc();
        chk("bounce_di_at", first_at[1], 7);
        chk("bounce_di_cnt", pcnt[1], 1);
        chk("bounce_overrun", pcnt[5], 0);
        $display("bounce: di at %0d after final rise, pulses %0d", first_at[1], pcnt[1]);

        // 3. Simultaneous inputs: qu, di, ni, soda on consecutive cycles
        apply_reset();
        clear_acc();
        raw_ni = 1; raw_di = 1; raw_qu = 1; raw_soda = 1;
        repeat (16) cyc();
        chk("simul_qu_at", first_at[0], 7);
        chk("simul_di_at", first_at[1], 8);
        chk("simul_ni_at", first_at[2], 9);
        chk("simul_soda_at", first_at[3], 10);
        chk("simul_total", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] + pcnt[4], 4);
        chk("simul_mutex", multi, 0);
        chk("simul_cc", int'(cc_a), 3);
        $display("simultaneous: qu %0d di %0d ni %0d soda %0d cc %0d",
                 first_at[0], first_at[1], first_at[2], first_at[3], cc_a);

        // 4. Reset mid-debounce: rst low before edges 3,4; pulse at 5+7=12
        apply_reset();
        clear_acc();
        raw_ni = 1;
        for (int j = 0; j < 20; j++) begin
            if (j == 3) rst = 1'b0;
            if (j == 5) rst = 1'b1;
            cyc();
        end
        chk("rstmid_ni_at", first_at[2], 12);
        chk("rstmid_ni_cnt", pcnt[2], 1);
        chk("rstmid_cc", int'(cc_a), 1);
        $display("reset mid-debounce: ni at %0d", first_at[2]);

        // 5. Merge on short-debounce instance: second diet edge while pending
        apply_reset();
        mon_sel = 2;
        clear_acc();
        raw_qu = 1; raw_di = 1; raw_ni = 1; raw_soda = 1; raw_diet = 1;
        for (int j = 0; j < 14; j++) begin
            if (j == 2) raw_diet = 0;
            if (j == 4) raw_diet = 1;
            cyc();
        end
        chk("merge_diet_cnt", pcnt[4], 1);
        chk("merge_diet_at", first_at[4], 8);
        chk("merge_ovr_cnt", pcnt[5], 1);
        chk("merge_ovr_at", first_at[5], 7);
        chk("merge_mutex", multi, 0);
        chk("merge_cc", int'(cc_c), 3);
        $display("merge: diet at %0d, overrun at %0d", first_at[4], first_at[5]);

        // 6. Serve and re-arm on the same edge: two diet pulses, no overrun
        apply_reset();
        clear_acc();
        raw_qu = 1; raw_diet = 1;
        for (int j = 0; j < 12; j++) begin
            if (j == 1) raw_diet = 0;
            if (j == 2) raw_diet = 1;
            cyc();
        end
        chk("rearm_qu_at", first_at[0], 4);
        chk("rearm_diet_at", first_at[4], 5);
        chk("rearm_diet_cnt", pcnt[4], 2);
        chk("rearm_overrun", pcnt[5], 0);
        $display("re-arm: diet first at %0d, pulses %0d", first_at[4], pcnt[4]);

        // 7. Coin counter wrap on the 2-bit instance: 1, 2, 3, 0, 1
        apply_reset();
        mon_sel = 0;
        clear_acc();
        for (int e = 0; e < 5; e++) begin
            raw_di = 1;
            repeat (10) cyc();
            raw_di = 0;
            repeat (10) cyc();
            chk($sformatf("wrap_cc_b_%0d", e), int'(cc_b), (e + 1) % 4);
            $display("wrap: dime %0d coin_count(2b) %0d", e + 1, cc_b);
        end
        chk("wrap_di_cnt", pcnt[1], 5);
        chk("wrap_cc_a", int'(cc_a), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
